// File: rtl/merge2_rr_if.sv
// rtl/merge2_rr_if.sv - valid/ready flit link used on the merge2_rr inputs and output
interface merge2_rr_if #(
  parameter int W = 9
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/merge2_rr.sv
// rtl/merge2_rr.sv - two-input round-robin merge of flits with per-input FIFOs and a registered output
module merge2_rr #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  merge2_rr_if.slave  in0,
  merge2_rr_if.slave  in1,
  merge2_rr_if.master out,
  output logic        out_src
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem0 [DEPTH];
  logic [W-1:0]  mem1 [DEPTH];
  logic [AW-1:0] wp0, rp0, wp1, rp1;
  logic [CW-1:0] cnt0, cnt1;
  logic          last;
  logic          push0, push1, pop0, pop1, load;

  // Ready looks only at the registered count, so a same-cycle pop never lets a full FIFO accept.
  assign in0.ready = !reset && (cnt0 < FULL);
  assign in1.ready = !reset && (cnt1 < FULL);
  assign push0     = in0.valid && in0.ready;
  assign push1     = in1.valid && in1.ready;
  assign load      = !out.valid || out.ready;

  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (load) begin
      if ((cnt0 != '0) && (cnt1 != '0)) begin
        pop0 = last;
        pop1 = !last;
      end else begin
        pop0 = (cnt0 != '0);
        pop1 = (cnt1 != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push0) mem0[wp0] <= in0.data;
    if (push1) mem1[wp1] <= in1.data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp0       <= '0;
      rp0       <= '0;
      cnt0      <= '0;
      wp1       <= '0;
      rp1       <= '0;
      cnt1      <= '0;
      last      <= 1'b1;
      out.valid <= 1'b0;
      out.data  <= '0;
      out_src   <= 1'b0;
    end else begin
      if (push0) wp0 <= wp0 + 1'b1;
      if (push1) wp1 <= wp1 + 1'b1;
      if (pop0)  rp0 <= rp0 + 1'b1;
      if (pop1)  rp1 <= rp1 + 1'b1;

      if (push0 && !pop0)      cnt0 <= cnt0 + 1'b1;
      else if (!push0 && pop0) cnt0 <= cnt0 - 1'b1;
      if (push1 && !pop1)      cnt1 <= cnt1 + 1'b1;
      else if (!push1 && pop1) cnt1 <= cnt1 - 1'b1;

      // Data and source are left alone when the output drains empty.
      if (pop0) begin
        out.data  <= mem0[rp0];
        out_src   <= 1'b0;
        last      <= 1'b0;
        out.valid <= 1'b1;
      end else if (pop1) begin
        out.data  <= mem1[rp1];
        out_src   <= 1'b1;
        last      <= 1'b1;
        out.valid <= 1'b1;
      end else if (load) begin
        out.valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_merge2_rr.sv
// tb/tb_merge2_rr.sv - self-checking bench for merge2_rr
module tb_merge2_rr;
  localparam int W = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic out_src;

  merge2_rr_if #(.W(W)) i0 ();
  merge2_rr_if #(.W(W)) i1 ();
  merge2_rr_if #(.W(W)) o ();

  merge2_rr #(.W(W), .DEPTH(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .in0     (i0),
    .in1     (i1),
    .out     (o),
    .out_src (out_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           port;
    logic [W-1:0] data;
    logic         src;
  } vec_t;

  int passed = 0;
  int total  = 0;
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  logic [W:0]   outlog [$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Transfers are recorded at the falling edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (!reset && o.valid && o.ready) begin
      outlog.push_back({out_src, o.data});
      if (out_src == 1'b0) begin
        if (q0.size() > 0) check("sb_in0", int'(o.data), int'(q0.pop_front()));
        else begin
          total++;
          $display("FAIL sb_in0_spurious: got 0x%0h expected no flit", o.data);
        end
      end else begin
        if (q1.size() > 0) check("sb_in1", int'(o.data), int'(q1.pop_front()));
        else begin
          total++;
          $display("FAIL sb_in1_spurious: got 0x%0h expected no flit", o.data);
        end
      end
    end
  end

  task automatic send(input int p, input logic [W-1:0] d);
    int   n;
    logic acc;
    n = 0;
    if (p == 0) begin i0.data = d; i0.valid = 1'b1; end
    else        begin i1.data = d; i1.valid = 1'b1; end
    forever begin
      @(negedge clk);
      acc = (p == 0) ? i0.ready : i1.ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 300) begin
        total++;
        $display("FAIL send_timeout: port %0d flit 0x%0h not accepted", p, d);
        break;
      end
    end
    if (acc) begin
      if (p == 0) q0.push_back(d);
      else        q1.push_back(d);
    end
    if (p == 0) i0.valid = 1'b0;
    else        i1.valid = 1'b0;
  endtask

  task automatic stream(input int p, input int n, input logic [W-1:0] base);
    for (int k = 0; k < n; k++) send(p, base + W'(k + 1));
  endtask

  task automatic wait_log(input string name, input int n);
    int c;
    c = 0;
    while (outlog.size() < n && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    check(name, outlog.size(), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [4];
    logic [W:0] exp_c [6];

    tbl[0] = '{0, 9'h1A3, 1'b0};
    tbl[1] = '{1, 9'h0F5, 1'b1};
    tbl[2] = '{0, 9'h000, 1'b0};
    tbl[3] = '{1, 9'h1FF, 1'b1};
    exp_c  = '{{1'b0, 9'h101}, {1'b1, 9'h0F1}, {1'b0, 9'h102},
               {1'b1, 9'h0F2}, {1'b0, 9'h103}, {1'b1, 9'h0F3}};

    i0.data = '0; i0.valid = 1'b0;
    i1.data = '0; i1.valid = 1'b0;
    o.ready = 1'b1;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_in0_ready", int'(i0.ready), 0);
    check("rst_in1_ready", int'(i1.ready), 0);
    check("rst_out_valid", int'(o.valid), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_out_valid", int'(o.valid), 0);
    check("idle_out_data", int'(o.data), 0);
    check("idle_out_src", int'(out_src), 0);
    check("idle_in0_ready", int'(i0.ready), 1);
    check("idle_in1_ready", int'(i1.ready), 1);

    // Contention: round-robin starts with in0 after reset
    outlog.delete();
    fork
      stream(0, 3, 9'h100);
      stream(1, 3, 9'h0F0);
    join
    wait_log("cont_count", 6);
    for (int k = 0; k < 6; k++) check($sformatf("cont_order%0d", k), int'(outlog[k]), int'(exp_c[k]));

    // Single-flit latency table
    for (int v = 0; v < 4; v++) begin
      send(tbl[v].port, tbl[v].data);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_valid", v), int'(o.valid), 1);
      check($sformatf("tbl%0d_data", v), int'(o.data), int'(tbl[v].data));
      check($sformatf("tbl%0d_src", v), int'(out_src), int'(tbl[v].src));
      @(posedge clk); #1;
      check($sformatf("tbl%0d_drain", v), int'(o.valid), 0);
    end

    // Backpressure fills the in1 FIFO
    outlog.delete();
    o.ready = 1'b0;
    fork
      stream(1, 4, 9'h140);
      begin
        repeat (6) @(posedge clk);
        #1;
        check("bp_valid", int'(o.valid), 1);
        check("bp_data", int'(o.data), 9'h141);
        check("bp_src", int'(out_src), 1);
        check("bp_full", int'(i1.ready), 0);
        repeat (2) @(posedge clk);
        #1;
        check("bp_hold", int'(o.data), 9'h141);
        check("bp_still_full", int'(i1.ready), 0);
        o.ready = 1'b1;
      end
    join
    wait_log("bp_count", 4);
    for (int k = 0; k < 4; k++) check($sformatf("bp_order%0d", k), int'(outlog[k]), int'({1'b1, 9'h141 + 9'(k)}));

    // Pointer wrap with toggling out_ready
    outlog.delete();
    o.ready = 1'b1;
    fork
      stream(0, 10, 9'h0A0);
      begin
        int c;
        c = 0;
        while (outlog.size() < 10 && c < 400) begin
          @(posedge clk); #1;
          o.ready = ~o.ready;
          c++;
        end
      end
    join
    o.ready = 1'b1;
    wait_log("wrap_count", 10);
    for (int k = 0; k < 10; k++) check($sformatf("wrap_order%0d", k), int'(outlog[k]), int'({1'b0, 9'h0A1 + 9'(k)}));
    @(posedge clk); #1;

    // Mid-operation reset with a held output and a full FIFO
    o.ready = 1'b0;
    stream(0, 3, 9'h060);
    check("mr_pre_valid", int'(o.valid), 1);
    check("mr_pre_full", int'(i0.ready), 0);
    reset = 1'b1;
    #1;
    check("mr_async_valid", int'(o.valid), 0);
    check("mr_async_data", int'(o.data), 0);
    check("mr_in0_ready", int'(i0.ready), 0);
    q0.delete();
    q1.delete();
    outlog.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    o.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mr_no_stale", outlog.size(), 0);
    send(1, 9'h055);
    wait_log("mr_new_count", 1);
    if (outlog.size() > 0) check("mr_new_flit", int'(outlog[0]), int'({1'b1, 9'h055}));

    @(posedge clk); #1;
    check("sb_drained", q0.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
